// File: rtl/mem_arbiter.sv
// Byte-serial arbiter/sequencer sharing the 8-bit RAM/IO port between instruction fetch and the LSB.
// Optional macro MEM_ARB_STARVE_GUARD_EN bounds how many LS grants can pass a waiting fetch.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        rdy,
    input  logic        flush,
    input  logic        io_buffer_full,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_data,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [1:0]  ls_size,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    input  logic [7:0]  mem_din,
    output logic [7:0]  mem_dout,
    output logic [31:0] mem_a,
    output logic        mem_wr,
    output logic [1:0]  o_dbg_state
);

    // Requests are level handshakes: req is held until the one-cycle ack, and the
    // requester drops or changes it on the edge that ends the ack cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, READ = 2'd1, WRITE = 2'd2, ACK = 2'd3} state_t;

    state_t      r_state;
    state_t      w_state_next;
    logic        r_owner_ls;
    logic [31:0] r_base;
    logic [2:0]  r_n;
    logic [2:0]  r_cnt;
    logic [31:0] r_data;
    logic [31:0] r_if_data;
    logic [31:0] r_ls_rdata;

    logic        w_ls_elig;
    logic        w_force_if;
    logic        w_grant_ls;
    logic        w_grant_if;
    logic [2:0]  w_ls_n;
    logic [1:0]  w_cap_idx;
    logic [31:0] w_asm;
    logic [31:0] w_result;

    assign o_dbg_state = r_state;
    assign if_data     = r_if_data;
    assign ls_rdata    = r_ls_rdata;
    assign if_ack      = (r_state == ACK) && !r_owner_ls;
    assign ls_ack      = (r_state == ACK) && r_owner_ls;

`ifdef MEM_ARB_STARVE_GUARD_EN
    logic [2:0] r_starve;

    assign w_force_if = (r_starve == 3'(STARVE_LIMIT)) && if_req;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_starve <= 3'd0;
        end else if (rdy && r_state == IDLE) begin
            if (w_grant_if || (w_grant_ls && !if_req)) begin
                r_starve <= 3'd0;
            end else if (w_grant_ls) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end
`else
    assign w_force_if = 1'b0;
`endif

    // An IO store cannot be started while the UART buffer has no room.
    assign w_ls_elig  = ls_req && !(ls_we && ls_addr[17:16] == 2'b11 && io_buffer_full);
    assign w_grant_ls = w_ls_elig && !w_force_if && !flush;
    assign w_grant_if = if_req && !w_grant_ls && !flush;
    assign w_cap_idx  = 2'(r_cnt - 3'd1);

    always_comb begin
        w_ls_n = 3'd4;
        case (ls_size)
            2'b00:   w_ls_n = 3'd1;
            2'b01:   w_ls_n = 3'd2;
            default: w_ls_n = 3'd4;
        endcase
    end

    // RAM data lags the address by one cycle, so byte cnt-1 arrives while cnt is driven.
    always_comb begin
        w_asm = r_data;
        if (r_cnt != 3'd0) begin
            case (w_cap_idx)
                2'd0: w_asm[7:0]   = mem_din;
                2'd1: w_asm[15:8]  = mem_din;
                2'd2: w_asm[23:16] = mem_din;
                2'd3: w_asm[31:24] = mem_din;
            endcase
        end
        case (r_n)
            3'd1:    w_result = {24'd0, w_asm[7:0]};
            3'd2:    w_result = {16'd0, w_asm[15:0]};
            default: w_result = w_asm;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_grant_ls) begin
                    w_state_next = ls_we ? WRITE : READ;
                end else if (w_grant_if) begin
                    w_state_next = READ;
                end
            end
            READ: begin
                if (flush) begin
                    w_state_next = IDLE;
                end else if (r_cnt == r_n) begin
                    w_state_next = ACK;
                end
            end
            WRITE: begin
                if (r_cnt == r_n - 3'd1) begin
                    w_state_next = ACK;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        mem_a    = 32'd0;
        mem_dout = 8'd0;
        mem_wr   = 1'b0;
        case (r_state)
            READ: begin
                if (r_cnt < r_n) begin
                    mem_a = r_base + {29'd0, r_cnt};
                end else begin
                    mem_a = r_base + {29'd0, r_n} - 32'd1;
                end
            end
            WRITE: begin
                mem_a  = r_base + {29'd0, r_cnt};
                mem_wr = rdy;
                case (r_cnt[1:0])
                    2'd0: mem_dout = r_data[7:0];
                    2'd1: mem_dout = r_data[15:8];
                    2'd2: mem_dout = r_data[23:16];
                    2'd3: mem_dout = r_data[31:24];
                endcase
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_owner_ls <= 1'b0;
            r_base     <= 32'd0;
            r_n        <= 3'd0;
            r_cnt      <= 3'd0;
            r_data     <= 32'd0;
            r_if_data  <= 32'd0;
            r_ls_rdata <= 32'd0;
        end else if (rdy) begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (w_grant_ls || w_grant_if) begin
                        r_cnt      <= 3'd0;
                        r_owner_ls <= w_grant_ls;
                        r_base     <= w_grant_ls ? ls_addr : if_addr;
                        r_n        <= w_grant_ls ? w_ls_n : 3'd4;
                        if (w_grant_ls && ls_we) begin
                            r_data <= ls_wdata;
                        end
                    end
                end
                READ: begin
                    if (!flush) begin
                        r_data <= w_asm;
                        r_cnt  <= r_cnt + 3'd1;
                        if (r_cnt == r_n) begin
                            if (r_owner_ls) begin
                                r_ls_rdata <= w_result;
                            end else begin
                                r_if_data <= w_result;
                            end
                        end
                    end
                end
                WRITE: r_cnt <= r_cnt + 3'd1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a byte RAM model with one-cycle read latency feeds the port.
// Expected values are hand-derived from the transfer timing and RAM contents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        rdy;
    logic        flush;
    logic        io_buffer_full;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_ack;
    logic [31:0] if_data;
    logic        ls_req;
    logic        ls_we;
    logic [1:0]  ls_size;
    logic [31:0] ls_addr;
    logic [31:0] ls_wdata;
    logic        ls_ack;
    logic [31:0] ls_rdata;
    logic [7:0]  mem_din;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic [1:0]  o_dbg_state;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  ram [0:4095];
    logic [31:0] wd;
    logic [9:0]  exp_if;
    int          n_acks;

    mem_arbiter #(.STARVE_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .rdy(rdy), .flush(flush),
        .io_buffer_full(io_buffer_full),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_data(if_data),
        .ls_req(ls_req), .ls_we(ls_we), .ls_size(ls_size), .ls_addr(ls_addr),
        .ls_wdata(ls_wdata), .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .o_dbg_state(o_dbg_state)
    );

    always #5 clk = ~clk;

    // Synchronous RAM: read data appears the cycle after the address.
    always @(posedge clk) begin
        mem_din <= ram[mem_a[11:0]];
        if (mem_wr) ram[mem_a[11:0]] <= mem_dout;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        ram[12'h010] = 8'h13; ram[12'h011] = 8'h05; ram[12'h012] = 8'h00; ram[12'h013] = 8'h00;
        ram[12'h102] = 8'h34; ram[12'h103] = 8'h12;
        ram[12'h020] = 8'h93; ram[12'h021] = 8'h00; ram[12'h022] = 8'h10; ram[12'h023] = 8'h00;
        mem_din = 8'h00;
        reset = 1'b0; rdy = 1'b1; flush = 1'b0; io_buffer_full = 1'b0;
        if_req = 1'b0; if_addr = 32'h10;
        ls_req = 1'b0; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'd0; ls_wdata = 32'd0;

        // Reset
        tick(); tick();
        chk("rst_state", 32'(o_dbg_state), 32'd0);
        chk("rst_if_ack", 32'(if_ack), 32'd0);
        chk("rst_ls_ack", 32'(ls_ack), 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_ls_rdata", ls_rdata, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        reset = 1'b1;
        tick();

        // Word fetch at 0x10
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("fetch_state_read", 32'(o_dbg_state), 32'd1);
        for (int k = 0; k < 5; k++) begin
            chk("fetch_mem_a", mem_a, 32'h10 + 32'((k < 4) ? k : 3));
            chk("fetch_no_early_ack", 32'(if_ack), 32'd0);
            tick();
        end
        chk("fetch_ack", 32'(if_ack), 32'd1);
        chk("fetch_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();
        chk("fetch_back_idle", 32'(o_dbg_state), 32'd0);

        // Half load concurrent with fetch: LS first
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b01; ls_addr = 32'h102; if_req = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            chk("half_mem_a", mem_a, 32'h102 + 32'((k < 2) ? k : 1));
            tick();
        end
        chk("half_ls_ack", 32'(ls_ack), 32'd1);
        chk("half_if_ack", 32'(if_ack), 32'd0);
        chk("half_rdata", ls_rdata, 32'h0000_1234);
        ls_req = 1'b0;
        tick();
        chk("half_then_idle", 32'(o_dbg_state), 32'd0);
        tick();
        chk("half_then_if_grant", 32'(o_dbg_state), 32'd1);
        chk("half_then_if_addr", mem_a, 32'h10);
        repeat (5) tick();
        chk("half_then_if_ack", 32'(if_ack), 32'd1);
        chk("half_then_if_data", if_data, 32'h0000_0513);
        if_req = 1'b0;
        tick();

        // Word store with a flush in the middle
        wd = 32'hDEAD_BEEF;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b10; ls_addr = 32'h200; ls_wdata = wd;
        tick();
        for (int k = 0; k < 4; k++) begin
            chk("store_mem_wr", 32'(mem_wr), 32'd1);
            chk("store_mem_a", mem_a, 32'h200 + 32'(k));
            chk("store_mem_dout", 32'(mem_dout), 32'(wd[8*k +: 8]));
            flush = (k == 1);
            tick();
        end
        chk("store_ack", 32'(ls_ack), 32'd1);
        chk("store_ack_wr_low", 32'(mem_wr), 32'd0);
        ls_req = 1'b0; ls_we = 1'b0;
        tick();

        // Byte store interrupted by rdy=0
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h300; ls_wdata = 32'h0000_00AB;
        tick();
        chk("bst_wr", 32'(mem_wr), 32'd1);
        chk("bst_dout", 32'(mem_dout), 32'hAB);
        rdy = 1'b0;
        #1;
        chk("bst_wr_frozen", 32'(mem_wr), 32'd0);
        tick();
        chk("bst_state_held", 32'(o_dbg_state), 32'd2);
        rdy = 1'b1;
        #1;
        chk("bst_redrive_wr", 32'(mem_wr), 32'd1);
        chk("bst_redrive_a", mem_a, 32'h300);
        chk("bst_redrive_dout", 32'(mem_dout), 32'hAB);
        tick();
        chk("bst_ack", 32'(ls_ack), 32'd1);
        ls_req = 1'b0; ls_we = 1'b0;
        tick();

        // Flush in IDLE blocks the grant; flush mid-fetch aborts
        if_req = 1'b1; if_addr = 32'h20; flush = 1'b1;
        tick();
        chk("idle_flush_no_grant", 32'(o_dbg_state), 32'd0);
        flush = 1'b0;
        tick(); tick(); tick();
        chk("abort_cnt2_addr", mem_a, 32'h22);
        flush = 1'b1;
        tick();
        chk("abort_state_idle", 32'(o_dbg_state), 32'd0);
        chk("abort_no_ack", 32'(if_ack), 32'd0);
        flush = 1'b0;
        tick();
        chk("abort_regrant", 32'(o_dbg_state), 32'd1);
        chk("abort_regrant_addr", mem_a, 32'h20);
        repeat (5) tick();
        chk("abort_refetch_ack", 32'(if_ack), 32'd1);
        chk("abort_refetch_data", if_data, 32'h0010_0093);
        if_req = 1'b0;
        tick();

        // IO store blocked by a full UART buffer
        io_buffer_full = 1'b1;
        ls_req = 1'b1; ls_we = 1'b1; ls_size = 2'b00; ls_addr = 32'h0003_0000; ls_wdata = 32'h5A;
        if_req = 1'b1; if_addr = 32'h10;
        tick();
        chk("io_if_granted", mem_a, 32'h10);
        chk("io_if_no_wr", 32'(mem_wr), 32'd0);
        repeat (5) tick();
        chk("io_if_ack", 32'(if_ack), 32'd1);
        if_req = 1'b0;
        tick();
        tick();
        chk("io_store_waits", 32'(o_dbg_state), 32'd0);
        io_buffer_full = 1'b0;
        tick();
        chk("io_store_wr", 32'(mem_wr), 32'd1);
        chk("io_store_a", mem_a, 32'h0003_0000);
        chk("io_store_dout", 32'(mem_dout), 32'h5A);
        tick();
        chk("io_store_ack", 32'(ls_ack), 32'd1);
        ls_req = 1'b0; ls_we = 1'b0;
        tick();

        // Continuous LS loads plus a waiting fetch
`ifdef MEM_ARB_STARVE_GUARD_EN
        exp_if = 10'b10000_10000;
`else
        exp_if = 10'b00000_00000;
`endif
        ls_req = 1'b1; ls_we = 1'b0; ls_size = 2'b00; ls_addr = 32'h102;
        if_req = 1'b1; if_addr = 32'h10;
        n_acks = 0;
        for (int t = 0; t < 120 && n_acks < 10; t++) begin
            tick();
            if (if_ack || ls_ack) begin
                chk("arb_order_if_ack", 32'(if_ack), 32'(exp_if[n_acks]));
                if (ls_ack) chk("arb_ls_rdata", ls_rdata, 32'h34);
                n_acks++;
            end
        end
        chk("arb_ack_count", 32'(n_acks), 32'd10);
        ls_req = 1'b0; if_req = 1'b0;
        tick(); tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
